aes128_key_expander: RTL and testbench
======================================

Name: aes128_key_expander

Overview:
- Iterative AES-128 key schedule. Accepts one 128-bit cipher key and streams the 11 round keys (round 0 to round 10) to the round datapath, one per valid/ready handshake.
- Sits directly downstream of the byte S-box. It instantiates four S-box instances to form SubWord on the rotated last word of the current round key.
- Its output feeds the AddRoundKey stage of the cipher core.

Parameters:
- NUM_ROUNDS, 10: index of the final round key. Legal range is 1..10. The Rcon table is fixed to AES values 01,02,04,08,10,20,40,80,1b,36.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- key_valid  in  1  key_in is presented
- key_ready  out  1  block can accept a new key
- key_in  in  128  cipher key; bits [127:120] are key byte 0 (FIPS-197 order)
- rk_valid  out  1  rk_out holds a valid round key
- rk_ready  in  1  downstream accepts rk_out
- rk_out  out  128  current round key, same byte order as key_in
- rk_index  out  4  round number of rk_out, 0..NUM_ROUNDS
- rk_last  out  1  high when rk_valid is high and rk_index == NUM_ROUNDS

Behaviour:
- One clock, synchronous active-high reset. All state is registered on the rising edge of clk.
- Reset values:
  - state = IDLE
  - rk_valid = 0
  - rk_out = 0
  - rk_index = 0
  - rk_last = 0
- key_ready = (state == IDLE) && !reset. It is combinational from state. While reset is high, key_valid is ignored.
- State IDLE:
  - key_ready = 1, rk_valid = 0.
  - On key_valid && key_ready: rk_out <= key_in, rk_index <= 0, rk_valid <= 1, state <= RUN.
- State RUN:
  - key_ready = 0, rk_valid = 1.
  - While rk_ready = 0: rk_out and rk_index hold exactly, with no advance.
  - On rk_ready with rk_index < NUM_ROUNDS: rk_out <= next_key(rk_out, rk_index + 1), rk_index <= rk_index + 1.
  - On rk_ready with rk_index == NUM_ROUNDS: rk_valid <= 0, state <= IDLE. rk_out and rk_index keep their last values; only rk_valid qualifies them.
- next_key(K, r), with w0..w3 = K[127:96], K[95:64], K[63:32], K[31:0]:
  - t = SubWord(RotWord(w3)) ^ {Rcon[r], 24'h0}
  - RotWord({a,b,c,d}) = {b,c,d,a}
  - SubWord applies the S-box to each byte.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - Result is {n0,n1,n2,n3}.
  - Computation is purely combinational within one cycle; it involves no carries, only XOR.
- Latency and throughput:
  - A key accepted at edge T gives round key 0 valid after T.
  - With rk_ready tied high, round keys 0..NUM_ROUNDS appear on NUM_ROUNDS+1 consecutive cycles.
  - key_ready returns the cycle after the last handshake, so the minimum key-to-key period is NUM_ROUNDS+2 cycles.
- Boundary conditions:
  - key_valid asserted during RUN is ignored. key_in is not sampled and the upstream must hold it.
  - rk_ready toggling arbitrarily must never skip or repeat a round key.
  - Reset mid-RUN aborts immediately: next cycle is IDLE with rk_valid = 0 and no partial key output.
  - Reset asserted in the same cycle as key_valid: reset wins and the key is not accepted.
  - rk_index never exceeds NUM_ROUNDS and never wraps.
- No X propagation: rk_out is defined at all times after reset.

Test Plan:
- FIPS-197 A.1 vector:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready = 1.
  - Required: rk0 = key, rk1 = a0fafe1788542cb123a339392a6c7605, rk2 = f2c295f27a96b9435935807a7359f67f, rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Required: 11 consecutive valid cycles; rk_last high only with rk10; key_ready high one cycle later.
- All-zero key:
  - Required: rk1 = 62636363626363636263636362636363 and rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure:
  - Stimulus: A.1 key with rk_ready driven by a random 30% duty pattern.
  - Required: same 11 keys in order, rk_out and rk_index stable whenever rk_valid && !rk_ready, no drops or duplicates.
- Reset mid-run:
  - Stimulus: assert reset for 1 cycle while rk_index == 4.
  - Required: next cycle rk_valid = 0, rk_out = 0, rk_index = 0, key_ready = 1.
  - Required: a following zero key yields a correct full sequence.
- Key during RUN:
  - Stimulus: hold key_valid = 1 with a different key_in during RUN.
  - Required: key_ready = 0, sequence unaffected.
  - Required: the new key is accepted at the first IDLE cycle and its rk0 equals that key_in.
- Back-to-back keys:
  - Stimulus: two keys queued with key_valid held high.
  - Required: second rk0 appears exactly NUM_ROUNDS+2 cycles after the first rk0.

Source files
------------

// File: rtl/aes128_key_expander.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : aes128_key_expander (with aes_sbox)                             |
// | Brief    : Iterative AES-128 key schedule, one round key per handshake.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    // Byte 0x00 sits in the most significant byte, so entry n starts at bit 8*(255-n).
    localparam logic [2047:0] c_sbox_table = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] w_bit_pos;

    assign w_bit_pos = {~i_byte, 3'b000};
    assign o_byte    = c_sbox_table[w_bit_pos +: 8];
endmodule

module aes128_key_expander #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_index,
    output logic         rk_last
);
    localparam logic       c_st_idle  = 1'b0;
    localparam logic       c_st_run   = 1'b1;
    localparam logic [3:0] c_last_idx = 4'(NUM_ROUNDS);

    logic         r_state;
    logic         r_rk_valid;
    logic [127:0] r_rk_out;
    logic [3:0]   r_rk_index;
    logic         r_rk_last;

    logic [3:0]   w_next_idx;
    logic [7:0]   w_rcon;
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;

    assign key_ready = (r_state == c_st_idle) && !reset;
    assign rk_valid  = r_rk_valid;
    assign rk_out    = r_rk_out;
    assign rk_index  = r_rk_index;
    assign rk_last   = r_rk_last;

    assign w_next_idx = r_rk_index + 4'd1;

    assign w_w0  = r_rk_out[127:96];
    assign w_w1  = r_rk_out[95:64];
    assign w_w2  = r_rk_out[63:32];
    assign w_w3  = r_rk_out[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (w_rot[8*gi +: 8]),
                .o_byte (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    always_comb begin
        w_rcon = 8'h00;
        case (w_next_idx)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_t  = w_sub ^ {w_rcon, 24'h000000};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_rk_valid <= 1'b0;
            r_rk_out   <= 128'h0;
            r_rk_index <= 4'd0;
            r_rk_last  <= 1'b0;
        end else if (r_state == c_st_idle) begin
            if (key_valid) begin
                r_rk_out   <= key_in;
                r_rk_index <= 4'd0;
                r_rk_valid <= 1'b1;
                r_rk_last  <= 1'b0;
                r_state    <= c_st_run;
            end
        end else if (rk_ready) begin
            // Final key leaves data/index in place; only rk_valid drops.
            if (r_rk_index == c_last_idx) begin
                r_rk_valid <= 1'b0;
                r_rk_last  <= 1'b0;
                r_state    <= c_st_idle;
            end else begin
                r_rk_out   <= {w_n0, w_n1, w_n2, w_n3};
                r_rk_index <= w_next_idx;
                r_rk_last  <= (w_next_idx == c_last_idx);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_aes128_key_expander.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_aes128_key_expander                                          |
// | Brief    : Self-checking bench with a FIPS-197 style key schedule model.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_aes128_key_expander;
    localparam int NR = 10;

    logic         clk;
    logic         reset;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_index;
    logic         rk_last;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] exp_rk   [0:10];
    logic [127:0] obs_rk   [0:10];

    aes128_key_expander #(.NUM_ROUNDS(NR)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_out    (rk_out),
        .rk_index  (rk_index),
        .rk_last   (rk_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // S-box derived from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] v);
        logic [7:0] inv = 8'h00;
        if (v != 8'h00) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, v);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*(3-i) +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [127:0] key, input bit hold);
        int n = 0;
        key_in    = key;
        key_valid = 1'b1;
        #1;
        while (!key_ready && n < 50) begin
            tick();
            n++;
        end
        check("key_ready_wait", key_ready, 1);
        tick();
        if (!hold) key_valid = 1'b0;
    endtask

    // Consumes one full round-key stream; stalls must repeat the same expected key.
    task automatic stream(input logic [127:0] key, input int pct, input string tag);
        int e = 0;
        int n = 0;
        expand(key);
        while (e <= NR && n < 600) begin
            rk_ready = ($urandom_range(99) < pct);
            #1;
            check({tag, "_valid"}, rk_valid, 1);
            check({tag, "_rk"}, rk_out, exp_rk[e]);
            check({tag, "_index"}, rk_index, e);
            check({tag, "_last"}, rk_last, (e == NR));
            check({tag, "_key_ready_run"}, key_ready, 0);
            obs_rk[e] = rk_out;
            tick();
            if (rk_ready) e++;
            n++;
        end
        check({tag, "_completed"}, e, NR + 1);
        if (pct >= 100) check({tag, "_consecutive"}, n, NR + 1);
        rk_ready = 1'b0;
        #1;
        check({tag, "_valid_after"}, rk_valid, 0);
        check({tag, "_key_ready_after"}, key_ready, 1);
    endtask

    initial begin
        logic [127:0] ka, kb, kc, kd;
        int n, t1, t2;

        reset     = 1'b1;
        key_valid = 1'b0;
        key_in    = 128'h0;
        rk_ready  = 1'b0;
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_ref(8'(i));

        repeat (2) tick();
        check("key_ready_in_reset", key_ready, 0);
        reset = 1'b0;
        #1;
        check("reset_rk_valid", rk_valid, 0);
        check("reset_rk_out", rk_out, 128'h0);
        check("reset_rk_index", rk_index, 0);
        check("reset_rk_last", rk_last, 0);
        check("reset_key_ready", key_ready, 1);

        ka = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        send_key(ka, 1'b0);
        stream(ka, 100, "a1");
        check("a1_rk0", obs_rk[0], ka);
        check("a1_rk1", obs_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("a1_rk2", obs_rk[2], 128'hf2c295f27a96b9435935807a7359f67f);
        check("a1_rk10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        send_key(128'h0, 1'b0);
        stream(128'h0, 100, "zero");
        check("zero_rk1", obs_rk[1], 128'h62636363626363636263636362636363);
        check("zero_rk10", obs_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        send_key(ka, 1'b0);
        stream(ka, 30, "bp30");

        for (int k = 0; k < 3; k++) begin
            kb = {$urandom, $urandom, $urandom, $urandom};
            send_key(kb, 1'b0);
            stream(kb, 50, "rand");
        end

        // Reset while round key 4 is on the bus.
        send_key(ka, 1'b0);
        rk_ready = 1'b1;
        n = 0;
        while (rk_index != 4'd4 && n < 20) begin
            tick();
            n++;
        end
        check("mid_reached_idx4", rk_index, 4);
        reset = 1'b1;
        #1;
        check("mid_key_ready_in_reset", key_ready, 0);
        tick();
        reset    = 1'b0;
        rk_ready = 1'b0;
        #1;
        check("mid_rk_valid", rk_valid, 0);
        check("mid_rk_out", rk_out, 128'h0);
        check("mid_rk_index", rk_index, 0);
        check("mid_key_ready", key_ready, 1);
        send_key(128'h0, 1'b0);
        stream(128'h0, 100, "post_reset_zero");

        // Reset coinciding with key_valid must not accept the key.
        reset     = 1'b1;
        key_valid = 1'b1;
        key_in    = {$urandom, $urandom, $urandom, $urandom};
        tick();
        reset     = 1'b0;
        key_valid = 1'b0;
        #1;
        check("rst_key_not_accepted", rk_valid, 0);
        tick();
        check("rst_key_still_idle", rk_valid, 0);

        // A different key held during RUN is only taken at the next IDLE cycle.
        kb = {$urandom, $urandom, $urandom, $urandom};
        send_key(ka, 1'b0);
        key_in    = kb;
        key_valid = 1'b1;
        stream(ka, 60, "hold_run");
        tick();
        key_valid = 1'b0;
        stream(kb, 100, "held_key");
        check("held_key_rk0", obs_rk[0], kb);

        // Back-to-back keys with key_valid held high.
        kc = {$urandom, $urandom, $urandom, $urandom};
        kd = {$urandom, $urandom, $urandom, $urandom};
        send_key(kc, 1'b1);
        t1 = cyc;
        stream(kc, 100, "b2b_first");
        key_in = kd;
        tick();
        t2 = cyc;
        key_valid = 1'b0;
        check("b2b_period", t2 - t1, NR + 2);
        stream(kd, 100, "b2b_second");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
